debounce_edge_multi: RTL and testbench

DEBOUNCE_EDGE_MULTI -- requirements
Module: debounce_edge_multi

---
 rtl/debounce_edge_multi_pkg.sv | 21 ++
 rtl/debounce_edge_multi_chan.sv | 126 ++++++++++++
 rtl/debounce_edge_multi.sv | 54 +++++
 tb/tb_debounce_edge_multi.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_multi_pkg.sv
// ---------------------------------------------------------------------------
// debounce_edge_multi_pkg
// Shared project timing constants for the key/switch debouncer plus a small
// helper used to bring raw inputs to a "1 = pressed" polarity.
//   T_20MS : 20 ms of stable input at 50 MHz (debounce window)
//   T_1S   : 1 s of held press at 50 MHz (long-press threshold)
// ---------------------------------------------------------------------------
package debounce_edge_multi_pkg;

  localparam int unsigned DB_CNT_W = 20;
  localparam int unsigned LP_CNT_W = 26;

  localparam logic [DB_CNT_W-1:0] T_20MS = 20'hF_4240;
  localparam logic [LP_CNT_W-1:0] T_1S   = 26'h2FA_F080;

  // Map a raw pin level to the internal "1 = pressed" convention.
  function automatic logic norm_level(input logic raw, input logic active_low);
    return raw ^ active_low;
  endfunction

endpackage

// File: rtl/debounce_edge_multi_chan.sv
// ---------------------------------------------------------------------------
// debounce_chan
// One independent debounce channel: 2-flop synchroniser, stability counter,
// registered press/release pulses and long-press detection.
// Ports:
//   clk    : rising-edge clock
//   n_rst  : asynchronous active-low reset (everything returns to released)
//   din    : raw asynchronous key/switch level
//   dout   : debounced level, 1 = pressed
//   rise   : one-cycle pulse in the first cycle dout shows a press
//   fall   : one-cycle pulse in the first cycle dout shows a release
//   long_p : one-cycle pulse when the press has lasted T_LONG cycles
//   long_l : held from long_p until the debounced release
// ---------------------------------------------------------------------------
module debounce_chan
  import debounce_edge_multi_pkg::*;
#(
  parameter int unsigned         CNT_W      = DB_CNT_W,
  parameter logic [CNT_W-1:0]    T_DB       = CNT_W'(T_20MS),
  parameter int unsigned         LP_W       = LP_CNT_W,
  parameter logic [LP_W-1:0]     T_LONG     = LP_W'(T_1S),
  parameter logic                ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic long_p,
  output logic long_l
);

  localparam logic [CNT_W-1:0] T_DB_M1   = T_DB - CNT_W'(1);
  localparam logic [LP_W-1:0]  T_LONG_M1 = T_LONG - LP_W'(1);

  logic             s1_r;
  logic             s2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [LP_W-1:0]  lp_cnt_r;
  logic             dout_r;
  logic             rise_r;
  logic             fall_r;
  logic             long_p_r;
  logic             long_l_r;

  logic             diff_s;
  logic             accept_s;
  logic             rise_s;
  logic             fall_s;
  logic             long_p_s;
  logic             long_l_s;
  logic [CNT_W-1:0] cnt_s;
  logic [LP_W-1:0]  lp_cnt_s;

  // Next-state logic for debounce counter, edge pulses and long-press tracking.
  always_comb begin
    diff_s   = s2_r ^ dout_r;
    accept_s = diff_s && (cnt_r == T_DB_M1);
    rise_s   = accept_s && s2_r;
    fall_s   = accept_s && !s2_r;

    // Counter only runs while the synchronised input disagrees with dout;
    // it clears on agreement and on acceptance, so it can never wrap.
    if (!diff_s || accept_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end

    // Long-press counter: runs while pressed, saturates, and is cleared on
    // the release edge so a fall coinciding with the threshold cannot fire.
    if (!dout_r || fall_s) begin
      lp_cnt_s = '0;
    end else if (lp_cnt_r == T_LONG) begin
      lp_cnt_s = lp_cnt_r;
    end else begin
      lp_cnt_s = lp_cnt_r + LP_W'(1);
    end

    // Pulse exactly on the transition to T_LONG (saturated value differs).
    long_p_s = dout_r && !fall_s && (lp_cnt_r == T_LONG_M1);

    if (fall_s) begin
      long_l_s = 1'b0;
    end else if (long_p_s) begin
      long_l_s = 1'b1;
    end else if (!dout_r) begin
      long_l_s = 1'b0;
    end else begin
      long_l_s = long_l_r;
    end
  end

  // State and output registers with asynchronous clear to the released level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      cnt_r    <= '0;
      lp_cnt_r <= '0;
      dout_r   <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      long_p_r <= 1'b0;
      long_l_r <= 1'b0;
    end else begin
      s1_r     <= norm_level(din, ACTIVE_LOW);
      s2_r     <= s1_r;
      cnt_r    <= cnt_s;
      lp_cnt_r <= lp_cnt_s;
      dout_r   <= accept_s ? s2_r : dout_r;
      rise_r   <= rise_s;
      fall_r   <= fall_s;
      long_p_r <= long_p_s;
      long_l_r <= long_l_s;
    end
  end

  assign dout   = dout_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign long_p = long_p_r;
  assign long_l = long_l_r;

endmodule

// File: rtl/debounce_edge_multi.sv
// ---------------------------------------------------------------------------
// debounce_edge_multi
// D_W fully independent debounce channels with press/release pulses and
// long-press detection. All outputs are registered inside each channel.
// Ports:
//   clk    : rising-edge clock
//   n_rst  : asynchronous active-low reset
//   din    : [D_W] raw asynchronous key/switch inputs
//   dout   : [D_W] debounced levels, 1 = pressed
//   rise   : [D_W] one-cycle press pulses
//   fall   : [D_W] one-cycle release pulses
//   long_p : [D_W] one-cycle long-press pulses
//   long_l : [D_W] long-press level, held until release
// ---------------------------------------------------------------------------
module debounce_edge_multi
  import debounce_edge_multi_pkg::*;
#(
  parameter int unsigned      D_W        = 4,
  parameter int unsigned      CNT_W      = DB_CNT_W,
  parameter logic [CNT_W-1:0] T_DB       = CNT_W'(T_20MS),
  parameter int unsigned      LP_W       = LP_CNT_W,
  parameter logic [LP_W-1:0]  T_LONG     = LP_W'(T_1S),
  parameter logic             ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [D_W-1:0] din,
  output logic [D_W-1:0] dout,
  output logic [D_W-1:0] rise,
  output logic [D_W-1:0] fall,
  output logic [D_W-1:0] long_p,
  output logic [D_W-1:0] long_l
);

  for (genvar i = 0; i < D_W; i++) begin : g_chan
    debounce_chan #(
      .CNT_W      (CNT_W),
      .T_DB       (T_DB),
      .LP_W       (LP_W),
      .T_LONG     (T_LONG),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk    (clk),
      .n_rst  (n_rst),
      .din    (din[i]),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .long_p (long_p[i]),
      .long_l (long_l[i])
    );
  end

endmodule

// File: tb/tb_debounce_edge_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge_multi
// Directed bench for debounce_edge_multi with T_DB=8, T_LONG=32, active-low
// keys. A vector table covers basic press/release/glitch/simultaneous cases;
// hand-written sequences cover long press and reset behaviour.
// ---------------------------------------------------------------------------
module tb_debounce_edge_multi;

  logic       clk;
  logic       n_rst;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] long_p;
  logic [3:0] long_l;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] seen;
  int         lp_count;

  typedef struct {
    logic [3:0] din;
    int         adv;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lp;
    logic [3:0] ll;
    logic [3:0] seen;
  } vec_t;

  vec_t tbl [18];

  debounce_edge_multi #(
    .D_W        (4),
    .CNT_W      (20),
    .T_DB       (20'd8),
    .LP_W       (26),
    .T_LONG     (26'd32),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .din    (din),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .long_p (long_p),
    .long_l (long_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    seen     = seen | rise | fall | long_p;
    lp_count = lp_count + int'(long_p[2]);
  endtask

  initial begin
    //          din    adv dout   rise   fall   lp     ll     seen
    tbl[0]  = '{4'hF,  3,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[1]  = '{4'hE,  9,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[2]  = '{4'hE,  1,  4'h1,  4'h1,  4'h0,  4'h0,  4'h0,  4'h1};
    tbl[3]  = '{4'hE,  1,  4'h1,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[4]  = '{4'hF,  9,  4'h1,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[5]  = '{4'hF,  1,  4'h0,  4'h0,  4'h1,  4'h0,  4'h0,  4'h1};
    tbl[6]  = '{4'hF,  1,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[7]  = '{4'hD,  5,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[8]  = '{4'hF,  20, 4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[9]  = '{4'h7,  10, 4'h8,  4'h8,  4'h0,  4'h0,  4'h0,  4'h8};
    tbl[10] = '{4'h7,  10, 4'h8,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[11] = '{4'hF,  9,  4'h8,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[12] = '{4'hF,  1,  4'h0,  4'h0,  4'h8,  4'h0,  4'h0,  4'h8};
    tbl[13] = '{4'hF,  40, 4'h0,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[14] = '{4'h5,  10, 4'hA,  4'hA,  4'h0,  4'h0,  4'h0,  4'hA};
    tbl[15] = '{4'hA,  10, 4'h5,  4'h5,  4'hA,  4'h0,  4'h0,  4'hF};
    tbl[16] = '{4'hA,  1,  4'h5,  4'h0,  4'h0,  4'h0,  4'h0,  4'h0};
    tbl[17] = '{4'hF,  10, 4'h0,  4'h0,  4'h5,  4'h0,  4'h0,  4'h5};

    seen     = 4'h0;
    lp_count = 0;
    n_rst    = 1'b0;
    din      = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.dout",   32'(dout),   32'h0);
    chk("reset.rise",   32'(rise),   32'h0);
    chk("reset.fall",   32'(fall),   32'h0);
    chk("reset.long_p", 32'(long_p), 32'h0);
    chk("reset.long_l", 32'(long_l), 32'h0);
    n_rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      din  = tbl[i].din;
      seen = 4'h0;
      repeat (tbl[i].adv) step();
      chk($sformatf("v%0d.dout", i),   32'(dout),   32'(tbl[i].dout));
      chk($sformatf("v%0d.rise", i),   32'(rise),   32'(tbl[i].rise));
      chk($sformatf("v%0d.fall", i),   32'(fall),   32'(tbl[i].fall));
      chk($sformatf("v%0d.long_p", i), 32'(long_p), 32'(tbl[i].lp));
      chk($sformatf("v%0d.long_l", i), 32'(long_l), 32'(tbl[i].ll));
      chk($sformatf("v%0d.pulses", i), 32'(seen),   32'(tbl[i].seen));
    end

    // Long press on channel 2: din held low 50 cycles
    din      = 4'hB;
    lp_count = 0;
    repeat (9) step();
    chk("long.pre_dout", 32'(dout), 32'h0);
    step();
    chk("long.rise_dout", 32'(dout), 32'h4);
    chk("long.rise", 32'(rise), 32'h4);
    repeat (31) step();
    chk("long.pre_long_p", 32'(long_p), 32'h0);
    chk("long.pre_long_l", 32'(long_l), 32'h0);
    step();
    chk("long.long_p", 32'(long_p), 32'h4);
    chk("long.long_l", 32'(long_l), 32'h4);
    step();
    chk("long.long_p_end", 32'(long_p), 32'h0);
    chk("long.long_l_hold", 32'(long_l), 32'h4);
    repeat (7) step();
    din = 4'hF;
    repeat (9) step();
    chk("long.rel_dout", 32'(dout), 32'h4);
    chk("long.rel_long_l", 32'(long_l), 32'h4);
    chk("long.rel_fall_early", 32'(fall), 32'h0);
    step();
    chk("long.fall", 32'(fall), 32'h4);
    chk("long.fall_long_l", 32'(long_l), 32'h0);
    chk("long.fall_dout", 32'(dout), 32'h0);
    step();
    chk("long.fall_end", 32'(fall), 32'h0);
    chk("long.long_p_count", 32'(lp_count), 32'd1);

    // Reset behaviour with all keys held
    din  = 4'h0;
    seen = 4'h0;
    repeat (12) step();
    chk("rst.pressed_dout", 32'(dout), 32'hF);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst.async_dout",   32'(dout),   32'h0);
    chk("rst.async_rise",   32'(rise),   32'h0);
    chk("rst.async_fall",   32'(fall),   32'h0);
    chk("rst.async_long_p", 32'(long_p), 32'h0);
    chk("rst.async_long_l", 32'(long_l), 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    seen  = 4'h0;
    repeat (4) step();
    chk("rst.midcount_pulses", 32'(seen), 32'h0);
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    seen  = 4'h0;
    repeat (9) step();
    chk("rst.post_dout_early", 32'(dout), 32'h0);
    chk("rst.post_pulses_early", 32'(seen), 32'h0);
    step();
    chk("rst.post_dout", 32'(dout), 32'hF);
    chk("rst.post_rise", 32'(rise), 32'hF);
    chk("rst.post_fall", 32'(fall), 32'h0);
    seen = 4'h0;
    repeat (5) step();
    chk("rst.no_fall", 32'(seen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
